// File: rtl/pipe_adder_pkg.sv
// rtl/pipe_adder_pkg.sv - shared mode encodings and configuration check for pipe_adder
package pipe_adder_pkg;

    // Operation select carried on the mode input
    localparam logic ADD = 1'b0;
    localparam logic SUB = 1'b1;

    // Legal configurations split WIDTH evenly into at least two chunk stages
    function automatic bit width_ok(input int width, input int stage_w);
        return (stage_w > 0) && ((width % stage_w) == 0) && ((width / stage_w) >= 2);
    endfunction

endpackage

// File: rtl/adder_chunk.sv
// rtl/adder_chunk.sv - STAGE_W-bit ripple of full-adder slices
module adder_chunk #(
    parameter int W = 4
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         cin_i,
    output logic [W-1:0] sum_o,
    output logic         cout_o,
    output logic         cmsb_o
);

    logic [W:0] carry;

    // Ripple the carry bit by bit; carry into the top slice feeds the overflow term
    always_comb begin
        carry    = '0;
        sum_o    = '0;
        carry[0] = cin_i;
        for (int i = 0; i < W; i++) begin
            sum_o[i]     = a_i[i] ^ b_i[i] ^ carry[i];
            carry[i + 1] = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
        end
        cout_o = carry[W];
        cmsb_o = carry[W - 1];
    end

endmodule

// File: rtl/pipe_adder.sv
// rtl/pipe_adder.sv - pipelined ripple-carry adder/subtractor with per-stage stall chain
module pipe_adder
    import pipe_adder_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int STAGE_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int STAGES = WIDTH / STAGE_W;

    if (!width_ok(WIDTH, STAGE_W)) begin : g_bad_cfg
        $error("pipe_adder: WIDTH must be a multiple of STAGE_W giving at least two stages");
    end

    // Stage registers: stage k holds the chunk k result, the lower sum bits and its carry.
    // Operands are only needed by later stages, so the last stage keeps none.
    logic [STAGES-1:0] v_q;
    logic [WIDTH-1:0]  a_q [0:STAGES-2];
    logic [WIDTH-1:0]  b_q [0:STAGES-2];
    logic [WIDTH-1:0]  s_q [0:STAGES-1];
    logic [STAGES-1:0] c_q;
    logic              ovf_q;

    // What each stage sees from upstream (ports for stage 0, previous register otherwise)
    logic [STAGES-1:0] up_v;
    logic [STAGES-1:0] up_c;
    logic [WIDTH-1:0]  up_a [0:STAGES-1];
    logic [WIDTH-1:0]  up_b [0:STAGES-1];
    logic [WIDTH-1:0]  up_s [0:STAGES-1];

    logic [STAGE_W-1:0] ch_sum [0:STAGES-1];
    logic [STAGES-1:0]  ch_cout;
    logic [STAGES-1:0]  ch_cmsb;

    logic [WIDTH-1:0]  s_d [0:STAGES-1];
    logic              ovf_d;
    logic [STAGES:0]   rdy;

    // Upstream view per stage; subtract is a + ~b + 1, so cin is dropped in SUB mode
    always_comb begin
        up_v    = '0;
        up_c    = '0;
        up_v[0] = in_valid;
        up_a[0] = a;
        up_s[0] = '0;
        case (mode)
            SUB: begin
                up_b[0] = ~b;
                up_c[0] = 1'b1;
            end
            default: begin
                up_b[0] = b;
                up_c[0] = cin;
            end
        endcase
        for (int k = 1; k < STAGES; k++) begin
            up_v[k] = v_q[k - 1];
            up_c[k] = c_q[k - 1];
            up_a[k] = a_q[k - 1];
            up_b[k] = b_q[k - 1];
            up_s[k] = s_q[k - 1];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_chunk
        adder_chunk #(
            .W (STAGE_W)
        ) u_chunk (
            .a_i    (up_a[k][k*STAGE_W +: STAGE_W]),
            .b_i    (up_b[k][k*STAGE_W +: STAGE_W]),
            .cin_i  (up_c[k]),
            .sum_o  (ch_sum[k]),
            .cout_o (ch_cout[k]),
            .cmsb_o (ch_cmsb[k])
        );
    end

    // Merge each chunk result into the running sum word; overflow only matters at the MSB chunk
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            s_d[k] = up_s[k];
            s_d[k][k*STAGE_W +: STAGE_W] = ch_sum[k];
        end
        ovf_d = ch_cmsb[STAGES-1] ^ ch_cout[STAGES-1];
    end

    // Stage k may load unless it and every stage downstream are full while the consumer stalls
    always_comb begin
        logic full;
        rdy         = '0;
        full        = 1'b0;
        rdy[STAGES] = out_ready;
        for (int k = 0; k < STAGES; k++) begin
            full = 1'b1;
            for (int j = k; j < STAGES; j++) begin
                full = full & v_q[j];
            end
            rdy[k] = !full || out_ready;
        end
    end

    // Advance stages that are free; data only moves with a valid token so outputs hold when empty
    always_ff @(posedge clk) begin
        if (rst) begin
            v_q   <= '0;
            c_q   <= '0;
            ovf_q <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                s_q[k] <= '0;
            end
            for (int k = 0; k < STAGES - 1; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (rdy[k]) begin
                    v_q[k] <= up_v[k];
                    if (up_v[k]) begin
                        s_q[k] <= s_d[k];
                        c_q[k] <= ch_cout[k];
                    end
                end
            end
            for (int k = 0; k < STAGES - 1; k++) begin
                if (rdy[k] && up_v[k]) begin
                    a_q[k] <= up_a[k];
                    b_q[k] <= up_b[k];
                end
            end
            if (rdy[STAGES-1] && up_v[STAGES-1]) begin
                ovf_q <= ovf_d;
            end
        end
    end

    // Already-consumed operand bits at the last stage and lower-chunk MSB carries are dead
    logic unused_bits;
    assign unused_bits = ^{up_a[STAGES-1][WIDTH-STAGE_W-1:0],
                           up_b[STAGES-1][WIDTH-STAGE_W-1:0],
                           ch_cmsb[STAGES-2:0]};

    assign in_ready  = rdy[0];
    assign out_valid = v_q[STAGES-1];
    assign sum       = s_q[STAGES-1];
    assign cout      = c_q[STAGES-1];
    assign ovf       = ovf_q;

endmodule

// File: doc/pipe_adder.md
Name: pipe_adder

Overview:
- Parametrised, pipelined ripple-carry adder/subtractor built from a chain of full-adder slices.
- The WIDTH-bit operation is split into STAGES chunks of STAGE_W bits, one chunk per pipeline register stage, with a carry passed between stages.
- Valid/ready handshakes on both input and output; per-stage stall propagation so no transaction is dropped or duplicated.
- Sits in the datapath as the standard add/sub unit for accumulators and address arithmetic.

Parameters:
- WIDTH, 16, operand and result width in bits; must be a multiple of STAGE_W.
- STAGE_W, 4, bits resolved per pipeline stage.
- STAGES, WIDTH/STAGE_W (derived, localparam), pipeline depth and latency in cycles.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands present.
- in_ready  output  1  block accepts operands this cycle.
- a  input  WIDTH  operand A (two's complement or unsigned).
- b  input  WIDTH  operand B.
- cin  input  1  carry-in, used only when mode=0.
- mode  input  1  0 = add (a+b+cin), 1 = subtract (a-b).
- out_valid  output  1  result present.
- out_ready  input  1  downstream accepts result.
- sum  output  WIDTH  result modulo 2^WIDTH.
- cout  output  1  carry-out of the MSB; for subtract, 1 means no borrow (a>=b unsigned).
- ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB.

Behaviour:
- Reset: rst=1 at a clock edge clears all stage valid bits. out_valid=0, sum=0, cout=0, ovf=0 from the next cycle. in_ready=1 once rst is deasserted.
- Reset mid-operation: all in-flight transactions are discarded, with no partial output.
- Input transfer occurs when in_valid && in_ready. Output transfer occurs when out_valid && out_ready.
- Operand preparation at capture:
  - mode=1: B' = ~b and carry0 = 1 (cin ignored).
  - mode=0: B' = b and carry0 = cin.
- Stage k (0..STAGES-1) adds bits [k*STAGE_W +: STAGE_W] of a and B' plus the carry from stage k-1 (carry0 for k=0).
- Stage k holds its computed partial sum, the upper unconsumed operand bits, the lower completed sum bits and its carry.
- The ovf term is evaluated in the last stage only.
- Latency: exactly STAGES cycles from input transfer to out_valid with out_ready held high. Throughput is 1 result/cycle.
- Stall rule: stage_ready[k] = !v[k] || stage_ready[k+1], with stage_ready[STAGES] = out_ready. in_ready = stage_ready[0], so it is combinational from out_ready through the chain.
- A stalled stage holds all its data stable, and out_valid/sum/cout/ovf stay stable while out_valid && !out_ready.
- Simultaneous accept and emit on a full pipeline with out_ready=1: both occur in the same cycle, with no bubble.
- Empty pipeline: out_valid=0. The sum/cout/ovf values are held from the last result and are don't-care to consumers.
- Wrap-around: sum is truncated to WIDTH bits, and the carry appears only on cout.
- Order is strictly FIFO. No reordering, and no dropping under any out_ready pattern.

Decomposition:
- Shared package: mode encoding constants ADD=1'b0 and SUB=1'b1, plus a WIDTH % STAGE_W == 0 elaboration check.
- One sub-module, adder_chunk: a STAGE_W-bit ripple of full-adder slices (xor/and/or per bit) with inputs a, b, cin and outputs sum, cout, and carry-into-MSB for ovf.
- pipe_adder instantiates STAGES copies of adder_chunk through a generate loop, plus the stage registers and the ready chain.

Test Plan:
- Reset then single add, a=16'h1234, b=16'h4321, cin=0, mode=0 -> out_valid exactly 4 cycles after transfer, sum=16'h5555, cout=0, ovf=0.
- Wrap and carry: a=16'hFFFF, b=16'h0001, cin=1 -> sum=16'h0001, cout=1, ovf=0. Signed overflow: a=16'h7FFF, b=16'h0001, cin=0 -> sum=16'h8000, cout=0, ovf=1.
- Subtract, mode=1:
  - a=16'h0005, b=16'h0007, cin=1 -> sum=16'hFFFE, cout=0 (borrow), ovf=0; cin is ignored.
  - a=16'h8000, b=16'h0001 -> sum=16'h7FFF, cout=1, ovf=1.
- Back-to-back stream of 20 random operands with out_ready=1 -> 20 results in order, one per cycle after 4-cycle fill. in_ready never drops.
- Backpressure:
  - out_ready=0 for 6 cycles while feeding -> in_ready falls after 4 accepted, output held stable.
  - out_ready returns to 1 -> all 4 drain in order with no loss or duplication, and simultaneous accept/emit is observed.
- Assert rst for one cycle with 3 transactions in flight -> out_valid=0 next cycle, none of the 3 ever emitted. A new operand afterwards returns its correct sum after 4 cycles.
